// File: rtl/axis_mem_feeder.sv
// Memory-to-AXI-Stream source: replays a block of words from a 1-cycle-latency
// synchronous memory, with valid throttling and optional auto-restart.

module axis_mem_feeder #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 20,
  parameter int LEN_W  = 32,
  parameter int THR_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [LEN_W-1:0]  cfg_length,
  input  logic [THR_W-1:0]  cfg_thr_period,
  input  logic [THR_W-1:0]  cfg_thr_on,
  input  logic              cfg_auto_restart,
  input  logic              restart_evt,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  beat_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [THR_W-1:0]  per_q;
  logic [THR_W-1:0]  on_q;
  logic              auto_q;
  logic [LEN_W-1:0]  issued;
  logic [THR_W-1:0]  phase;
  logic              mem_last;
  logic              rd_valid;
  logic              rd_last;

  logic [DATA_W-1:0] fifo_data [4];
  logic              fifo_last [4];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        fifo_cnt;

  logic              start_ok, rerun, zero_len, launch;
  logic [ADDR_W-1:0] l_base;
  logic [LEN_W-1:0]  l_len;
  logic              hs, final_hs, gate, fifo_empty, load, load_fifo, push, can_issue;
  logic [2:0]        cnt_nxt;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    start_ok   = start && !abort && (state == S_IDLE || state == S_WAIT);
    rerun      = restart_evt && !start && !abort && (state == S_WAIT);
    zero_len   = start_ok && (cfg_length == '0);
    launch     = (start_ok && !zero_len) || rerun;
    l_base     = start_ok ? cfg_base_addr : base_q;
    l_len      = start_ok ? cfg_length : len_q;

    hs         = m_axis_tvalid && m_axis_tready;
    final_hs   = hs && m_axis_tlast;
    gate       = (per_q == '0) || (phase < on_q);
    fifo_empty = (fifo_cnt == 3'd0);
    // Output register refills from the FIFO head, or straight from memory when the FIFO is empty.
    load       = (state == S_RUN) && (!m_axis_tvalid || hs) && gate && (!fifo_empty || rd_valid);
    load_fifo  = load && !fifo_empty;
    push       = rd_valid && !(load && fifo_empty);
    cnt_nxt    = fifo_cnt + {2'b00, push} - {2'b00, load_fifo};
    // Credit check: FIFO occupancy plus reads still in the memory pipeline never exceeds 4.
    can_issue  = (state == S_RUN) && (issued < len_q) &&
                 (({1'b0, cnt_nxt} + {3'b000, mem_rd_en}) < 4'd4);
  end

  // NOTE: FIFO storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_rd_data;
      fifo_last[wr_ptr] <= rd_last;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; later assignments in this block win.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      per_q         <= '0;
      on_q          <= '0;
      auto_q        <= 1'b0;
      issued        <= '0;
      phase         <= '0;
      mem_last      <= 1'b0;
      rd_valid      <= 1'b0;
      rd_last       <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      mem_rd_en     <= 1'b0;
      mem_addr      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      beat_cnt      <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= mem_rd_en;
      rd_last  <= mem_last;

      if (abort) begin
        state         <= S_IDLE;
        busy          <= 1'b0;
        mem_rd_en     <= 1'b0;
        rd_valid      <= 1'b0;
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        fifo_cnt      <= '0;
      end else begin
        if (push)      wr_ptr <= wr_ptr + 2'd1;
        if (load_fifo) rd_ptr <= rd_ptr + 2'd1;
        fifo_cnt <= cnt_nxt;

        if (load) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= fifo_empty ? mem_rd_data : fifo_data[rd_ptr];
          m_axis_tlast  <= fifo_empty ? rd_last : fifo_last[rd_ptr];
        end else if (hs) begin
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
        end
        if (hs) beat_cnt <= beat_cnt + LEN_W'(1);

        if (state == S_RUN && per_q != '0)
          phase <= (phase == per_q - THR_W'(1)) ? '0 : phase + THR_W'(1);

        mem_rd_en <= 1'b0;
        if (can_issue) begin
          mem_rd_en <= 1'b1;
          mem_addr  <= mem_addr + ADDR_W'(1);
          issued    <= issued + LEN_W'(1);
          mem_last  <= (issued == len_q - LEN_W'(1));
        end

        if (state == S_RUN && final_hs) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= auto_q ? S_WAIT : S_IDLE;
        end

        if (start_ok) begin
          base_q <= cfg_base_addr;
          len_q  <= cfg_length;
          per_q  <= cfg_thr_period;
          on_q   <= (cfg_thr_on == '0) ? THR_W'(1) : cfg_thr_on;
          auto_q <= cfg_auto_restart;
        end
        if (zero_len) begin
          done  <= 1'b1;
          state <= S_IDLE;
        end

        // Launch issues the first read on the launch edge itself.
        if (launch) begin
          state     <= S_RUN;
          busy      <= 1'b1;
          mem_rd_en <= 1'b1;
          mem_addr  <= l_base;
          issued    <= LEN_W'(1);
          mem_last  <= (l_len == LEN_W'(1));
          beat_cnt  <= '0;
          phase     <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_mem_feeder.sv
// Scoreboard bench for axis_mem_feeder: stimulus pushes expected beats, a negedge
// monitor pops and compares on every handshake and tracks timing of key events.

module tb_axis_mem_feeder;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 12;
  localparam int LEN_W  = 32;
  localparam int THR_W  = 10;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic [LEN_W-1:0]  cfg_length;
  logic [THR_W-1:0]  cfg_thr_period;
  logic [THR_W-1:0]  cfg_thr_on;
  logic              cfg_auto_restart;
  logic              restart_evt;
  logic              abort;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  beat_cnt;

  axis_mem_feeder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .THR_W(THR_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_length(cfg_length),
    .cfg_thr_period(cfg_thr_period), .cfg_thr_on(cfg_thr_on),
    .cfg_auto_restart(cfg_auto_restart), .restart_evt(restart_evt), .abort(abort),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done), .beat_cnt(beat_cnt)
  );

  int pass_cnt = 0;
  int check_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {16'hC0DE, 4'h0, a, 16'hBEEF, 4'h0, ~a};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_word(mem_addr);

  logic        rand_mode = 1'b0;
  logic        tready_fix = 1'b1;
  logic [15:0] lfsr = 16'hACE1;
  initial m_axis_tready = 1'b1;
  always @(posedge clk) begin
    #2;
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    m_axis_tready = rand_mode ? lfsr[0] : tready_fix;
  end

  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] e;
  int rd_count, first_rd, first_tv, first_hs, last_hs, run_hs;
  int done_count, done_cyc, last_rise, spacing_err, start_cyc;
  logic busy_at_done;
  logic [LEN_W-1:0] beat_at_done;
  logic hold_chk = 1'b0;
  logic prev_tvalid = 1'b0;
  logic prev_last;
  logic [DATA_W-1:0] prev_data;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd_en) begin
        rd_count++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (hold_chk) begin
        check("hold_tvalid", m_axis_tvalid, 1);
        check("hold_tdata", m_axis_tdata, prev_data);
        check("hold_tlast", m_axis_tlast, prev_last);
      end
      hold_chk  = m_axis_tvalid && !m_axis_tready && !abort;
      prev_data = m_axis_tdata;
      prev_last = m_axis_tlast;
      if (m_axis_tvalid && first_tv < 0) first_tv = cyc;
      if (m_axis_tvalid && !prev_tvalid) begin
        if (last_rise >= 0 && cyc - last_rise < 4) spacing_err++;
        last_rise = cyc;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        run_hs++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("beat_data", m_axis_tdata, e[DATA_W-1:0]);
          check("beat_last", m_axis_tlast, e[DATA_W]);
        end
      end
      if (done) begin
        done_count++;
        done_cyc     = cyc;
        busy_at_done = busy;
        beat_at_done = beat_cnt;
      end
      prev_tvalid = m_axis_tvalid;
    end
  end

  task automatic reset_stats();
    rd_count = 0; first_rd = -1; first_tv = -1; first_hs = -1; last_hs = -1;
    run_hs = 0; done_count = 0; done_cyc = -1; last_rise = -1; spacing_err = 0;
  endtask

  task automatic launch(input int base, input int len, input int per, input int on, input logic auto_r);
    @(posedge clk); #1;
    reset_stats();
    cfg_base_addr    = ADDR_W'(base);
    cfg_length       = LEN_W'(len);
    cfg_thr_period   = THR_W'(per);
    cfg_thr_on       = THR_W'(on);
    cfg_auto_restart = auto_r;
    start            = 1'b1;
    start_cyc        = cyc;
    for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), mem_word(ADDR_W'(base + i))});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_count == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_count == 0) check({name, "_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; restart_evt = 1'b0; abort = 1'b0;
    cfg_base_addr = '0; cfg_length = '0; cfg_thr_period = '0; cfg_thr_on = '0;
    cfg_auto_restart = 1'b0;
    reset_stats();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_busy_done", {busy, done, m_axis_tlast}, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_mem_addr", mem_addr, 0);

    // Plain run, no throttle, always ready.
    launch(32'h10, 8, 0, 0, 1'b0);
    wait_done("t1", 60);
    check("t1_first_rd", first_rd - start_cyc, 1);
    check("t1_first_tv", first_tv - start_cyc, 3);
    check("t1_burst", last_hs - first_hs, 7);
    check("t1_done_lat", done_cyc - last_hs, 1);
    check("t1_done_cnt", done_count, 1);
    check("t1_busy_done", busy_at_done, 0);
    check("t1_beat_cnt", beat_at_done, 8);
    check("t1_reads", rd_count, 8);
    check("t1_queue", exp_q.size(), 0);

    // Throttle P=4, on=1: one beat every 4 cycles.
    launch(32'h40, 12, 4, 1, 1'b0);
    wait_done("t2", 120);
    check("t2_first_tv", first_tv - start_cyc, 6);
    check("t2_span", last_hs - first_hs, 44);
    check("t2_spacing", spacing_err, 0);
    check("t2_reads", rd_count, 12);
    check("t2_queue", exp_q.size(), 0);

    // on >= P leaves the gate always open.
    launch(32'h80, 4, 3, 5, 1'b0);
    wait_done("t2b", 40);
    check("t2b_first_tv", first_tv - start_cyc, 3);
    check("t2b_span", last_hs - first_hs, 3);

    // on = 0 behaves as on = 1.
    launch(32'h90, 3, 2, 0, 1'b0);
    wait_done("t2c", 40);
    check("t2c_first_tv", first_tv - start_cyc, 4);
    check("t2c_span", last_hs - first_hs, 4);

    // Random backpressure.
    rand_mode = 1'b1;
    launch(32'h200, 64, 0, 0, 1'b0);
    wait_done("t3", 800);
    rand_mode = 1'b0;
    idle(2);
    check("t3_reads", rd_count, 64);
    check("t3_done_cnt", done_count, 1);
    check("t3_beat_cnt", beat_at_done, 64);
    check("t3_queue", exp_q.size(), 0);

    // Auto-restart.
    launch(32'h300, 4, 0, 0, 1'b1);
    wait_done("t4a", 40);
    idle(10);
    check("t4_wait_reads", rd_count, 4);
    check("t4_wait_busy", busy, 0);
    reset_stats();
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), mem_word(ADDR_W'(32'h300 + i))});
    restart_evt = 1'b1;
    start_cyc   = cyc;
    @(posedge clk); #1 restart_evt = 1'b0;
    @(posedge clk); #1 restart_evt = 1'b1;
    check("t4_busy_run", busy, 1);
    @(posedge clk); #1 restart_evt = 1'b0;
    wait_done("t4b", 40);
    idle(10);
    check("t4_restart_rd", first_rd - start_cyc, 1);
    check("t4_reads", rd_count, 4);
    check("t4_done_cnt", done_count, 1);
    check("t4_queue", exp_q.size(), 0);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    reset_stats();
    restart_evt = 1'b1;
    @(posedge clk); #1 restart_evt = 1'b0;
    idle(8);
    check("t4_idle_restart", rd_count, 0);

    // Zero-length start.
    launch(32'h50, 0, 0, 0, 1'b0);
    idle(5);
    check("t5_done_cnt", done_count, 1);
    check("t5_done_lat", done_cyc - start_cyc, 1);
    check("t5_reads", rd_count, 0);
    check("t5_no_tvalid", (first_tv < 0), 1);

    // Abort while stalled after 3 beats, then relaunch.
    tready_fix = 1'b1;
    launch(32'h500, 10, 0, 0, 1'b0);
    begin
      int n = 0;
      while (run_hs < 3 && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      tready_fix = 1'b0;
      if (run_hs < 3) check("t6_timeout", 0, 1);
    end
    idle(3);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t6_tvalid", m_axis_tvalid, 0);
    check("t6_tlast", m_axis_tlast, 0);
    check("t6_busy", busy, 0);
    idle(5);
    check("t6_no_done", done_count, 0);
    check("t6_beats", run_hs, 3);
    tready_fix = 1'b1;
    launch(32'h100, 5, 0, 0, 1'b0);
    wait_done("t6b", 40);
    check("t6_first_tv", first_tv - start_cyc, 3);
    check("t6_beat_cnt", beat_at_done, 5);
    check("t6_queue", exp_q.size(), 0);

    // start together with abort: abort wins.
    @(posedge clk); #1;
    reset_stats();
    cfg_length = 4; cfg_base_addr = 12'h20; cfg_auto_restart = 1'b0;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    idle(6);
    check("t7_reads", rd_count, 0);
    check("t7_done", done_count, 0);
    check("t7_tvalid", (first_tv < 0), 1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/axis_mem_feeder.md
# axis_mem_feeder

Parametrised memory-to-AXI-Stream source that replays a block of words from a synchronous-read memory onto an AXI-Stream master port.
- Programmable base address, beat count, valid-throttle duty pattern and auto-restart on a downstream completion event.
- Sits in front of the accelerator's s2mm input; used both as the on-chip weight/quant loader and as the self-test stimulus engine.
- Generalises the fixed-size, fixed-width feed loop into a reusable, re-launchable block.

## Interface
Parameters:
- DATA_W, 64, stream and memory data width
- ADDR_W, 20, memory word-address width
- LEN_W, 32, beat-count width
- THR_W, 10, throttle counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle launch pulse; ignored unless state is IDLE or WAIT_RESTART
- cfg_base_addr  in  ADDR_W  first word address, latched on launch
- cfg_length  in  LEN_W  beats per run, latched on launch
- cfg_thr_period  in  THR_W  throttle period P, latched; 0 = no throttle
- cfg_thr_on  in  THR_W  valid-enable cycles per period, latched; 0 treated as 1
- cfg_auto_restart  in  1  latched; re-run on restart_evt
- restart_evt  in  1  pulse (typically downstream tlast)
- abort  in  1  synchronous cancel, highest priority
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  read address
- mem_rd_data  in  DATA_W  valid the cycle after mem_rd_en
- m_axis_tdata  out  DATA_W  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  high on final beat of a run
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after final handshake
- beat_cnt  out  LEN_W  handshakes completed in current run

## Operation
- FSM states:
  - IDLE: start → RUN if cfg_length≠0; else done pulse, stay IDLE.
  - RUN: last handshake → WAIT_RESTART if cfg_auto_restart, else IDLE.
  - WAIT_RESTART: restart_evt or start → RUN with latched cfg (start reloads cfg from inputs; restart_evt reuses latched).
  - abort: any state → IDLE.
- Read engine: rd_addr starts at base, issued_cnt at 0. In RUN, a read issues when issued_cnt<length and (fifo_count+inflight)<4. Each read increments rd_addr (wraps modulo 2^ADDR_W) and issued_cnt.
- Prefetch FIFO: depth 4, entry = {last flag, data}. last flag is set on the read with issued_cnt==length-1. Guarantees 1 beat/cycle sustained with tready=1 and no throttle.
- Throttle: phase counter runs 0..P-1 in RUN and resets to 0 on launch. Gate = (P==0) or (phase < max(on,1)). on≥P means always open.
- tvalid rises only when FIFO is non-empty and gate is open. Once high, tvalid, tdata and tlast hold unchanged until handshake, regardless of gate.
- beat_cnt increments per handshake; clears on launch.
- abort: FIFO flushed, in-flight read data discarded, tvalid/tlast low next cycle, no done pulse.
- restart_evt in IDLE or RUN is ignored. start coinciding with abort: abort wins.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- All outputs are registered.
- Launch at edge k: mem_rd_en first high in cycle k+1. Data captured at edge k+2. tvalid first high in cycle k+3 (no throttle).
- Handshake = tvalid&tready at a rising edge. The next FIFO entry can present in the following cycle (no bubble).
- Final handshake at edge n: done high in cycle n+1, busy low in cycle n+1. From WAIT_RESTART, restart_evt at edge m gives mem_rd_en in cycle m+1.
- length=0 start at edge k: done in cycle k+1, no reads, no tvalid.
- Memory read latency fixed at 1. mem_rd_data is sampled exactly one edge after mem_rd_en.

## Test plan
- base=0x10, length=8, P=0, tready=1: tdata = mem[0x10..0x17] on 8 consecutive cycles, tlast on 8th only, tvalid first at start+3, done one cycle after last, beat_cnt=8.
- length=12, P=4, on=1, tready=1: tvalid rises at most once per 4 cycles; all 12 words in order; last beat ≤ 48 cycles after first.
- length=64, tready pseudo-random 50%: tvalid/tdata never change while tvalid&!tready; 64 words in order; no reads beyond 64.
- auto_restart=1, length=4, pulse restart_evt 10 cycles after done: second run replays same 4 words, second done; restart_evt during RUN is ignored.
- start with length=0: done pulse next cycle, mem_rd_en and tvalid never assert.
- abort after 3 of 10 beats with tvalid stalled: tvalid low next cycle, state IDLE, no done; new start (base=0x100) streams mem[0x100..] with no stale data.
